bcd_stopwatch: RTL and testbench

Parametrised BCD stopwatch for the typing-test datapath. It generalises the fixed 3-digit, up-only stopwatch into a configurable block with:
- an integrated tick prescaler;
- N BCD digits;
- up or down counting with saturation, preset load, and lap capture.

It feeds the seven-segment display driver and the test-control FSM, which watches `at_end` to end a test.

---
 rtl/bcd_stopwatch.sv | 124 ++++++++++++
 tb/tb_bcd_stopwatch.sv | 298 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/bcd_stopwatch.sv
// Parametrised BCD stopwatch: tick prescaler, N BCD digits, up/down counting
// with saturation at the terminal value, clamped preset load and lap capture.
module bcd_stopwatch #(
  parameter int unsigned TICK_DIV = 10000000,
  parameter int unsigned DIGITS   = 3
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic                  down,
  input  logic                  load,
  input  logic [4*DIGITS-1:0]   preset,
  input  logic                  lap,
  output logic [4*DIGITS-1:0]   count_out,
  output logic [4*DIGITS-1:0]   lap_out,
  output logic                  lap_valid,
  output logic                  tick_out,
  output logic                  at_end
);

  localparam int unsigned W  = 4 * DIGITS;
  localparam int unsigned PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
  localparam logic [PW-1:0] PRE_LAST = PW'(TICK_DIV - 1);

  logic [PW-1:0] pre_q, pre_d;
  logic [W-1:0]  cnt_q, cnt_d;
  logic [W-1:0]  lap_q, lap_d;
  logic          lv_q, lv_d;
  logic          tick_q, tick_d;

  logic [W-1:0]  next_cnt;
  logic [W-1:0]  preset_cl;
  logic [W-1:0]  all9;
  logic [3:0]    dig, nxt, pdig;
  logic          carry;
  logic          run, step;

  // Ripple BCD increment/decrement: carry (or borrow) only propagates past 9 (or 0).
  always_comb begin
    next_cnt  = '0;
    preset_cl = '0;
    all9      = '0;
    dig       = '0;
    nxt       = '0;
    pdig      = '0;
    carry     = 1'b1;
    for (int unsigned i = 0; i < DIGITS; i++) begin
      dig = cnt_q[4*i +: 4];
      nxt = dig;
      if (carry) begin
        if (down) begin
          if (dig == 4'd0) begin
            nxt = 4'd9;
          end else begin
            nxt   = dig - 4'd1;
            carry = 1'b0;
          end
        end else begin
          if (dig >= 4'd9) begin
            nxt = 4'd0;
          end else begin
            nxt   = dig + 4'd1;
            carry = 1'b0;
          end
        end
      end
      next_cnt[4*i +: 4]  = nxt;
      pdig                = preset[4*i +: 4];
      preset_cl[4*i +: 4] = (pdig > 4'd9) ? 4'd9 : pdig;
      all9[4*i +: 4]      = 4'd9;
    end
  end

  assign at_end = down ? (cnt_q == '0) : (cnt_q == all9);
  assign run    = start && !at_end;
  assign step   = run && (pre_q == PRE_LAST);

  always_comb begin
    pre_d  = pre_q;
    cnt_d  = cnt_q;
    lap_d  = lap_q;
    lv_d   = lv_q;
    tick_d = 1'b0;
    if (load) begin
      cnt_d = preset_cl;
      pre_d = '0;
      lv_d  = 1'b0;
    end else begin
      if (run) begin
        pre_d = step ? '0 : pre_q + 1'b1;
      end
      if (step) begin
        cnt_d  = next_cnt;
        tick_d = 1'b1;
      end
      if (lap) begin
        lap_d = cnt_q;
        lv_d  = 1'b1;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pre_q  <= '0;
      cnt_q  <= '0;
      lap_q  <= '0;
      lv_q   <= 1'b0;
      tick_q <= 1'b0;
    end else begin
      pre_q  <= pre_d;
      cnt_q  <= cnt_d;
      lap_q  <= lap_d;
      lv_q   <= lv_d;
      tick_q <= tick_d;
    end
  end

  assign count_out = cnt_q;
  assign lap_out   = lap_q;
  assign lap_valid = lv_q;
  assign tick_out  = tick_q;

endmodule

// File: tb/tb_bcd_stopwatch.sv
// Self-checking bench for bcd_stopwatch (TICK_DIV=4, DIGITS=3): directed
// scenarios against fixed values plus random traffic against an integer model.
module tb_bcd_stopwatch;

  localparam int TD   = 4;
  localparam int ND   = 3;
  localparam int MAXV = 999;

  logic        clk = 1'b0;
  logic        rst, start, down, load, lap;
  logic [11:0] preset;
  logic [11:0] count_out, lap_out;
  logic        lap_valid, tick_out, at_end;

  int n_checks = 0;
  int n_fail   = 0;

  // Reference model state: plain decimal integers.
  int m_cnt, m_pre, m_lap;
  bit m_lv, m_tick;

  always #5 clk = ~clk;

  bcd_stopwatch #(.TICK_DIV(TD), .DIGITS(ND)) dut (
    .clk(clk), .rst(rst), .start(start), .down(down), .load(load),
    .preset(preset), .lap(lap), .count_out(count_out), .lap_out(lap_out),
    .lap_valid(lap_valid), .tick_out(tick_out), .at_end(at_end)
  );

  function automatic logic [11:0] to_bcd(int v);
    logic [11:0] r;
    r = '0;
    for (int i = 0; i < ND; i++) begin
      r[4*i +: 4] = 4'(v % 10);
      v = v / 10;
    end
    return r;
  endfunction

  function automatic int clamp_val(logic [11:0] p);
    int v, mul, d;
    v = 0;
    mul = 1;
    for (int i = 0; i < ND; i++) begin
      d = int'(p[4*i +: 4]);
      if (d > 9) d = 9;
      v += d * mul;
      mul *= 10;
    end
    return v;
  endfunction

  function automatic bit m_at_end();
    return down ? (m_cnt == 0) : (m_cnt == MAXV);
  endfunction

  // Advance the model by one edge using the current inputs, then clock the DUT.
  task automatic cyc();
    bit run, stp;
    run = start && !m_at_end();
    stp = run && (m_pre == TD - 1);
    if (rst) begin
      m_cnt = 0; m_pre = 0; m_lap = 0; m_lv = 0; m_tick = 0;
    end else if (load) begin
      m_cnt = clamp_val(preset); m_pre = 0; m_lv = 0; m_tick = 0;
    end else begin
      if (lap) begin
        m_lap = m_cnt;
        m_lv  = 1;
      end
      m_tick = stp;
      if (stp) m_cnt = down ? m_cnt - 1 : m_cnt + 1;
      if (run) m_pre = stp ? 0 : m_pre + 1;
    end
    @(posedge clk);
    #1;
  endtask

  task automatic idle_inputs();
    rst = 0; start = 0; down = 0; load = 0; lap = 0; preset = '0;
  endtask

  task automatic test_reset();
    idle_inputs();
    rst = 1;
    cyc();
    rst = 0;
    n_checks++;
    if (count_out !== 12'h000) begin n_fail++; $display("FAIL reset_count: got %h want 000", count_out); end
    n_checks++;
    if (lap_out !== 12'h000) begin n_fail++; $display("FAIL reset_lap: got %h want 000", lap_out); end
    n_checks++;
    if (lap_valid !== 1'b0 || tick_out !== 1'b0) begin
      n_fail++; $display("FAIL reset_flags: lv=%b tick=%b want 0 0", lap_valid, tick_out);
    end
    n_checks++;
    if (at_end !== 1'b0) begin n_fail++; $display("FAIL reset_at_end_up: got %b want 0", at_end); end
    down = 1;
    #1;
    n_checks++;
    if (at_end !== 1'b1) begin n_fail++; $display("FAIL reset_at_end_down: got %b want 1", at_end); end
    down = 0;
  endtask

  task automatic test_up_run();
    int ticks;
    ticks = 0;
    idle_inputs();
    rst = 1;
    cyc();
    rst = 0;
    start = 1;
    for (int i = 1; i <= 40; i++) begin
      cyc();
      if (tick_out === 1'b1) ticks++;
      n_checks++;
      if (tick_out !== ((i % TD) == 0)) begin
        n_fail++; $display("FAIL up_tick_phase: cycle %0d got %b want %b", i, tick_out, (i % TD) == 0);
      end
    end
    n_checks++;
    if (count_out !== 12'h010) begin n_fail++; $display("FAIL up_run_count: got %h want 010", count_out); end
    n_checks++;
    if (ticks != 10) begin n_fail++; $display("FAIL up_run_ticks: got %0d want 10", ticks); end
  endtask

  task automatic test_carry_sat();
    int ticks;
    ticks = 0;
    idle_inputs();
    start = 1;
    load = 1; preset = 12'h998;
    cyc();
    load = 0;
    repeat (TD) cyc();
    n_checks++;
    if (count_out !== 12'h999 || at_end !== 1'b1) begin
      n_fail++; $display("FAIL carry_to_999: got %h at_end=%b want 999 1", count_out, at_end);
    end
    repeat (20) begin
      cyc();
      if (tick_out === 1'b1) ticks++;
    end
    n_checks++;
    if (count_out !== 12'h999 || ticks != 0) begin
      n_fail++; $display("FAIL saturate_up: got %h ticks=%0d want 999 0", count_out, ticks);
    end
  endtask

  task automatic test_down_run();
    int ticks;
    ticks = 0;
    idle_inputs();
    start = 1; down = 1;
    load = 1; preset = 12'h100;
    cyc();
    load = 0;
    repeat (TD) cyc();
    n_checks++;
    if (count_out !== 12'h099) begin n_fail++; $display("FAIL down_borrow: got %h want 099", count_out); end
    for (int i = 0; i < 99 * TD && count_out !== 12'h000; i++) cyc();
    n_checks++;
    if (count_out !== 12'h000 || at_end !== 1'b1) begin
      n_fail++; $display("FAIL down_to_zero: got %h at_end=%b want 000 1", count_out, at_end);
    end
    repeat (8) begin
      cyc();
      if (tick_out === 1'b1) ticks++;
    end
    n_checks++;
    if (count_out !== 12'h000 || ticks != 0) begin
      n_fail++; $display("FAIL saturate_down: got %h ticks=%0d want 000 0", count_out, ticks);
    end
  endtask

  task automatic test_lap_step();
    idle_inputs();
    start = 1;
    load = 1; preset = 12'h005;
    cyc();
    load = 0;
    repeat (TD - 1) cyc();
    lap = 1;
    cyc();
    lap = 0;
    n_checks++;
    if (lap_out !== 12'h005 || count_out !== 12'h006 || lap_valid !== 1'b1) begin
      n_fail++; $display("FAIL lap_on_step: lap=%h cnt=%h lv=%b want 005 006 1", lap_out, count_out, lap_valid);
    end
    load = 1; preset = 12'h200;
    cyc();
    load = 0;
    n_checks++;
    if (lap_valid !== 1'b0 || lap_out !== 12'h005 || count_out !== 12'h200) begin
      n_fail++; $display("FAIL load_clears_lv: lv=%b lap=%h cnt=%h want 0 005 200", lap_valid, lap_out, count_out);
    end
  endtask

  task automatic test_pause();
    idle_inputs();
    load = 1; preset = 12'h000;
    cyc();
    load = 0;
    start = 1;
    repeat (2) cyc();
    start = 0;
    repeat (10) cyc();
    n_checks++;
    if (count_out !== 12'h000 || tick_out !== 1'b0) begin
      n_fail++; $display("FAIL pause_hold: got %h tick=%b want 000 0", count_out, tick_out);
    end
    start = 1;
    cyc();
    n_checks++;
    if (count_out !== 12'h000) begin n_fail++; $display("FAIL resume_early: got %h want 000", count_out); end
    cyc();
    n_checks++;
    if (count_out !== 12'h001 || tick_out !== 1'b1) begin
      n_fail++; $display("FAIL resume_phase: got %h tick=%b want 001 1", count_out, tick_out);
    end
    start = 0;
    load = 1; preset = 12'hA3F;
    cyc();
    load = 0;
    n_checks++;
    if (count_out !== 12'h939) begin n_fail++; $display("FAIL preset_clamp: got %h want 939", count_out); end
  endtask

  task automatic test_priority();
    idle_inputs();
    start = 1;
    load = 1; preset = 12'h321;
    cyc();
    load = 0; lap = 1;
    cyc();
    rst = 1; load = 1; lap = 1; preset = 12'h777;
    cyc();
    rst = 0; load = 0; lap = 0;
    n_checks++;
    if (count_out !== 12'h000 || lap_out !== 12'h000 || lap_valid !== 1'b0 || tick_out !== 1'b0) begin
      n_fail++; $display("FAIL rst_priority: cnt=%h lap=%h lv=%b tick=%b want 000 000 0 0",
                         count_out, lap_out, lap_valid, tick_out);
    end
    repeat (TD - 1) cyc();
    load = 1; preset = 12'h050;
    cyc();
    load = 0;
    n_checks++;
    if (count_out !== 12'h050) begin n_fail++; $display("FAIL load_over_step: got %h want 050", count_out); end
  endtask

  task automatic test_random();
    int sel;
    idle_inputs();
    rst = 1;
    cyc();
    for (int i = 0; i < 3000; i++) begin
      rst   = ($urandom_range(0, 199) == 0);
      start = ($urandom_range(0, 7) != 0);
      if ($urandom_range(0, 59) == 0) down = ~down;
      load  = ($urandom_range(0, 39) == 0);
      lap   = ($urandom_range(0, 9) == 0);
      sel   = $urandom_range(0, 3);
      case (sel)
        0: preset = 12'($urandom);
        1: preset = 12'h998;
        2: preset = 12'h002;
        default: preset = to_bcd($urandom_range(0, MAXV));
      endcase
      cyc();
      n_checks++;
      if (count_out !== to_bcd(m_cnt) || lap_out !== to_bcd(m_lap) || lap_valid !== m_lv ||
          tick_out !== m_tick || at_end !== m_at_end()) begin
        n_fail++;
        $display("FAIL random_cycle_%0d: cnt=%h lap=%h lv=%b tick=%b end=%b want %h %h %b %b %b",
                 i, count_out, lap_out, lap_valid, tick_out, at_end,
                 to_bcd(m_cnt), to_bcd(m_lap), m_lv, m_tick, m_at_end());
      end
    end
  endtask

  initial begin
    idle_inputs();
    m_cnt = 0; m_pre = 0; m_lap = 0; m_lv = 0; m_tick = 0;
    #2;
    test_reset();
    test_up_run();
    test_carry_sat();
    test_down_run();
    test_lap_step();
    test_pause();
    test_priority();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
